// File: rtl/tetris_pkg.sv
// ============================================================================
// tetris_pkg: phase codes and one-hot screen-select encodings shared by the
// phase controller and the VGA output mux.  Rev 1.0
// ============================================================================
`default_nettype none

package tetris_pkg;

  localparam logic [1:0] PH_READY = 2'd0;
  localparam logic [1:0] PH_PLAY  = 2'd1;
  localparam logic [1:0] PH_OVER  = 2'd2;

  // Bit order is {gameready, start, over}, matching the mux select inputs.
  localparam logic [2:0] SEL_READY = 3'b100;
  localparam logic [2:0] SEL_PLAY  = 3'b010;
  localparam logic [2:0] SEL_OVER  = 3'b001;

  typedef enum logic [1:0] {
    ST_READY = PH_READY,
    ST_PLAY  = PH_PLAY,
    ST_OVER  = PH_OVER
  } phase_e;

  function automatic logic [2:0] phase_sel(input phase_e ph);
    logic [2:0] sel;
    sel = SEL_READY;
    case (ph)
      ST_READY: sel = SEL_READY;
      ST_PLAY:  sel = SEL_PLAY;
      ST_OVER:  sel = SEL_OVER;
      default:  sel = SEL_READY;
    endcase
    return sel;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tetris_phase_ctrl_key_debounce.sv
// ============================================================================
// key_debounce: 2-FF synchronizer, stability counter and one-cycle press
// pulse for an active-low push-button.  Rev 1.0
// ============================================================================
`default_nettype none

module key_debounce
  import tetris_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n_i,
  output logic press_o
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          deb_q, deb_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;

  // Counting only while the synced level differs from the accepted one means
  // any bounce back to the accepted level restarts the count.
  always_comb begin
    deb_d   = deb_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    if (sync_q[1] == deb_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      deb_d   = sync_q[1];
      cnt_d   = '0;
      press_d = deb_q & ~sync_q[1];
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b11;
      deb_q   <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], key_n_i};
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

`default_nettype wire

// File: rtl/tetris_phase_ctrl.sv
// ============================================================================
// tetris_phase_ctrl: READY/PLAY/OVER game-phase sequencer committing every
// phase change on a vsync frame boundary.  Rev 1.0
// ============================================================================
`default_nettype none

module tetris_phase_ctrl
  import tetris_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES     = 500000,
  parameter int   OVER_MIN_FRAMES     = 120,
  parameter int   OVER_TIMEOUT_FRAMES = 1800,
  parameter logic VSYNC_ACTIVE        = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_start_n,
  input  logic over_req,
  input  logic vsync_in,
  output logic gameready_sig,
  output logic start_sig,
  output logic over_sig,
  output logic game_clr,
  output logic frame_tick
);

  localparam int FCW = $clog2(OVER_TIMEOUT_FRAMES + 1);
  localparam logic [FCW-1:0] F_MIN = FCW'(OVER_MIN_FRAMES);
  localparam logic [FCW-1:0] F_MAX = FCW'(OVER_TIMEOUT_FRAMES);

  logic           press;
  logic           vsync_q;
  logic           fb;
  logic           key_ev, over_ev;
  logic           pend_key_q, pend_key_d;
  logic           pend_over_q, pend_over_d;
  phase_e         phase_q, phase_d;
  logic [FCW-1:0] fcnt_q, fcnt_d, fcnt_inc;
  logic [2:0]     sel_q, sel_d;
  logic           clr_q, clr_d;
  logic           tick_q;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_debounce (
    .clk    (clk),
    .rst_n  (rst_n),
    .key_n_i(key_start_n),
    .press_o(press)
  );

  assign fb = (vsync_in == VSYNC_ACTIVE) && (vsync_q != VSYNC_ACTIVE);

  // Events are filtered by phase before latching, so a dropped key in early
  // OVER or a stray over_req in READY never reaches the commit logic.
  assign key_ev  = press && ((phase_q == ST_READY) ||
                             ((phase_q == ST_OVER) && (fcnt_q >= F_MIN)));
  assign over_ev = over_req && (phase_q == ST_PLAY);
  assign fcnt_inc = (fcnt_q == F_MAX) ? fcnt_q : fcnt_q + 1'b1;

  always_comb begin
    phase_d     = phase_q;
    fcnt_d      = fcnt_q;
    clr_d       = 1'b0;
    pend_key_d  = pend_key_q | key_ev;
    pend_over_d = pend_over_q | over_ev;
    if (fb) begin
      pend_key_d  = 1'b0;
      pend_over_d = 1'b0;
      case (phase_q)
        ST_READY: begin
          if (pend_key_q || key_ev) begin
            phase_d = ST_PLAY;
            clr_d   = 1'b1;
          end
        end
        ST_PLAY: begin
          if (pend_over_q || over_ev) begin
            phase_d = ST_OVER;
            fcnt_d  = '0;
          end
        end
        ST_OVER: begin
          fcnt_d = fcnt_inc;
          if (pend_key_q || key_ev || (fcnt_inc == F_MAX)) begin
            phase_d = ST_READY;
          end
        end
        default: phase_d = ST_READY;
      endcase
    end
    sel_d = phase_sel(phase_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q     <= VSYNC_ACTIVE;
      pend_key_q  <= 1'b0;
      pend_over_q <= 1'b0;
      phase_q     <= ST_READY;
      fcnt_q      <= '0;
      sel_q       <= SEL_READY;
      clr_q       <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      vsync_q     <= vsync_in;
      pend_key_q  <= pend_key_d;
      pend_over_q <= pend_over_d;
      phase_q     <= phase_d;
      fcnt_q      <= fcnt_d;
      sel_q       <= sel_d;
      clr_q       <= clr_d;
      tick_q      <= fb;
    end
  end

  assign {gameready_sig, start_sig, over_sig} = sel_q;
  assign game_clr   = clr_q;
  assign frame_tick = tick_q;

endmodule

`default_nettype wire

// File: tb/tb_tetris_phase_ctrl.sv
// ============================================================================
// tb_tetris_phase_ctrl: frame-level reference model with scoreboard checking
// of phase flags, game_clr and frame_tick.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_tetris_phase_ctrl;
  import tetris_pkg::*;

  localparam int DEB   = 16;
  localparam int MINF  = 4;
  localparam int TOF   = 8;
  localparam int FRAME = 100;
  localparam int VLOW  = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic key_start_n = 1'b1;
  logic over_req = 1'b0;
  logic vsync_in = 1'b1;
  logic gameready_sig, start_sig, over_sig, game_clr, frame_tick;

  tetris_phase_ctrl #(
    .DEBOUNCE_CYCLES    (DEB),
    .OVER_MIN_FRAMES    (MINF),
    .OVER_TIMEOUT_FRAMES(TOF),
    .VSYNC_ACTIVE       (1'b0)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_start_n  (key_start_n),
    .over_req     (over_req),
    .vsync_in     (vsync_in),
    .gameready_sig(gameready_sig),
    .start_sig    (start_sig),
    .over_sig     (over_sig),
    .game_clr     (game_clr),
    .frame_tick   (frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] sel;
    logic       clr;
  } exp_t;

  int   total = 0;
  int   bad   = 0;
  exp_t expq[$];

  // Frame-level model: 0 = title, 1 = playing, 2 = game over.
  int ph     = 50;
  int m_mode = 0;
  int m_cnt  = 0;
  bit m_key  = 0;
  bit m_over = 0;
  bit in_rst = 1;
  bit ft_chk = 0;

  task automatic model_frame();
    if (m_mode == 0) begin
      if (m_key) begin
        m_mode = 1;
        expq.push_back('{sel: 3'b010, clr: 1'b1});
      end
    end else if (m_mode == 1) begin
      if (m_over) begin
        m_mode = 2;
        m_cnt  = 0;
        expq.push_back('{sel: 3'b001, clr: 1'b0});
      end
    end else begin
      if (m_cnt < TOF) m_cnt++;
      if (m_key || m_cnt == TOF) begin
        m_mode = 0;
        expq.push_back('{sel: 3'b100, clr: 1'b0});
      end
    end
    m_key  = 0;
    m_over = 0;
  endtask

  // vsync: low for the first VLOW cycles of each FRAME-cycle frame.
  initial begin
    forever begin
      @(negedge clk);
      ph = (ph + 1) % FRAME;
      vsync_in = (ph < VLOW) ? 1'b0 : 1'b1;
      if (ph == 0 && !in_rst) model_frame();
    end
  end

  task automatic wait_ph(input int k);
    do @(posedge clk); while (ph != k);
  endtask

  task automatic wait_frames(input int n);
    repeat (n) wait_ph(50);
  endtask

  task automatic press(input int len);
    @(negedge clk);
    key_start_n = 1'b0;
    if (m_mode == 0 || (m_mode == 2 && m_cnt >= MINF)) m_key = 1;
    repeat (len) @(negedge clk);
    key_start_n = 1'b1;
  endtask

  task automatic glitch(input int len);
    @(negedge clk);
    key_start_n = 1'b0;
    repeat (len) @(negedge clk);
    key_start_n = 1'b1;
  endtask

  task automatic pulse_over();
    @(negedge clk);
    over_req = 1'b1;
    if (m_mode == 1) m_over = 1;
    @(negedge clk);
    over_req = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every flag change or game_clr pulse must match the next expectation.
  logic [2:0] last_sel = 3'b100;
  logic [2:0] cur_sel;
  exp_t       e;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cur_sel = {gameready_sig, start_sig, over_sig};
      if (in_rst) begin
        last_sel = cur_sel;
      end else begin
        check("onehot", 32'($onehot(cur_sel)), 32'd1);
        if (ft_chk) check("frame_tick", 32'(frame_tick), 32'(ph == 0));
        if (cur_sel !== last_sel || game_clr !== 1'b0) begin
          if (expq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_change: got sel=%b clr=%b expected no change (t=%0t)",
                     cur_sel, game_clr, $time);
          end else begin
            e = expq.pop_front();
            check("sel_clr", 32'({cur_sel, game_clr}), 32'(e));
            check("commit_phase", 32'(ph), 32'd0);
          end
          last_sel = cur_sel;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int act, st, len;
  initial begin
    // 1: reset release
    repeat (3) @(negedge clk);
    wait_ph(50);
    @(negedge clk);
    rst_n = 1'b1;
    in_rst = 0;
    ft_chk = 1;
    #1;
    check("reset_sel", 32'({gameready_sig, start_sig, over_sig}), 32'b100);
    check("reset_clr", 32'(game_clr), 32'd0);
    wait_frames(3);

    // 2: glitch ignored, real press starts a game
    wait_ph(20); glitch(5);
    wait_frames(2);
    wait_ph(20); press(30);
    wait_frames(2);
    check("play_after_press", 32'({gameready_sig, start_sig, over_sig}), 32'b010);

    // 3: over_req mid-frame held off until the boundary
    wait_ph(50); pulse_over();
    wait_ph(70);
    check("play_held_midframe", 32'({gameready_sig, start_sig, over_sig}), 32'b010);
    wait_frames(1);
    check("over_entered", 32'({gameready_sig, start_sig, over_sig}), 32'b001);

    // 4: early press dropped, later press returns to title
    while (m_cnt < 2) wait_ph(20);
    wait_ph(20); press(30);
    while (m_cnt < MINF) wait_ph(20);
    wait_ph(20); press(30);
    wait_frames(2);
    check("ready_after_key", 32'({gameready_sig, start_sig, over_sig}), 32'b100);

    // 5: timeout back to title, then a new game
    wait_ph(20); press(30);
    wait_frames(1);
    wait_ph(30); pulse_over();
    wait_frames(TOF + 2);
    check("ready_after_timeout", 32'({gameready_sig, start_sig, over_sig}), 32'b100);
    wait_ph(20); press(30);
    wait_frames(2);

    // 6: over_req and press in the same frame, then async reset mid-OVER
    wait_ph(15); pulse_over(); press(30);
    wait_frames(2);
    check("over_wins", 32'({gameready_sig, start_sig, over_sig}), 32'b001);
    wait_ph(40);
    @(negedge clk);
    rst_n = 1'b0;
    in_rst = 1;
    ft_chk = 0;
    #1;
    check("async_reset_sel", 32'({gameready_sig, start_sig, over_sig}), 32'b100);
    check("async_reset_clr", 32'(game_clr), 32'd0);
    m_mode = 0; m_cnt = 0; m_key = 0; m_over = 0;
    expq.delete();
    wait_ph(50);
    @(negedge clk);
    rst_n = 1'b1;
    in_rst = 0;
    ft_chk = 1;

    // Random frames: one action per frame, kept clear of the boundary.
    for (int f = 0; f < 40; f++) begin
      wait_ph(10);
      act = $urandom_range(0, 4);
      st  = $urandom_range(15, 30);
      len = $urandom_range(25, 35);
      wait_ph(st);
      case (act)
        1: press(len);
        2: glitch($urandom_range(1, 8));
        3: pulse_over();
        4: begin pulse_over(); press(len); end
        default: ;
      endcase
      wait_ph(95);
    end

    wait_frames(2);
    check("queue_drained", 32'(expq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
